// File: rtl/modulo_debouncer_botoes.sv
// Push-button front end: two active-low raw keys (op_c = cork-load, op = operation select).
// Each key is synchronised, debounced and turned into a clean level plus a one-clk pulse.
// A held key can auto-repeat its pulse at a fixed period.
module modulo_debouncer_botoes #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned REPEAT_OP_C   = 0,
  parameter int unsigned REPEAT_OP     = 0,
  parameter int unsigned CNT_W         = 21
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic btn_op_c_i,
  input  logic btn_op_i,
  output logic op_c_pulse_o,
  output logic op_pulse_o,
  output logic op_c_level_o,
  output logic op_level_o
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Channel 0 = op_c, channel 1 = op.
  logic [1:0] btn_raw;
  logic [1:0] pulse;
  logic [1:0] level;

  assign btn_raw = {btn_op_i, btn_op_c_i};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    localparam int unsigned Repeat = (ch == 0) ? REPEAT_OP_C : REPEAT_OP;
    localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = (Repeat == 0) ? '0 : CNT_W'(Repeat - 1);

    logic             sync1_q;
    logic             sync2_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rep_q;
    logic             pulse_q;
    logic             level_q;
    logic             pressed;

    // Keys are active-low: a 0 out of the second sync flop means pressed.
    assign pressed = ~sync2_q;

    // Synchroniser, debounce FSM, counters and registered outputs for one key.
    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        state_q <= StIdle;
        cnt_q   <= '0;
        rep_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[ch];
        sync2_q <= sync1_q;
        pulse_q <= 1'b0;
        case (state_q)
          StIdle: begin
            if (pressed) begin
              state_q <= StPressWait;
              cnt_q   <= '0;
            end
          end
          StPressWait: begin
            if (!pressed) begin
              // Press shorter than the stable window: a glitch, drop it.
              state_q <= StIdle;
            end else if (cnt_q == StableLast) begin
              state_q <= StHeld;
              pulse_q <= 1'b1;
              rep_q   <= '0;
              level_q <= 1'b1;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          StHeld: begin
            if (!pressed) begin
              state_q <= StReleaseWait;
              cnt_q   <= '0;
            end else if (Repeat != 0) begin
              if (rep_q == RepeatLast) begin
                pulse_q <= 1'b1;
                rep_q   <= '0;
              end else begin
                rep_q <= sat_inc(rep_q);
              end
            end
          end
          StReleaseWait: begin
            if (pressed) begin
              // Release bounce: back to held, repeat phase restarts, no new pulse.
              state_q <= StHeld;
              rep_q   <= '0;
            end else if (cnt_q == StableLast) begin
              state_q <= StIdle;
              level_q <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign pulse[ch] = pulse_q;
    assign level[ch] = level_q;
  end

  assign op_c_pulse_o = pulse[0];
  assign op_pulse_o   = pulse[1];
  assign op_c_level_o = level[0];
  assign op_level_o   = level[1];

endmodule

// File: tb/tb_modulo_debouncer_botoes.sv
// Bench for modulo_debouncer_botoes: directed scenarios plus random key activity, with a
// run-length reference model feeding an expectation queue and a monitor that checks each cycle.
module tb_modulo_debouncer_botoes;

  localparam int unsigned S  = 4;
  localparam int unsigned RC = 6;
  localparam int unsigned RO = 0;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic btn_c = 1'b1;
  logic btn_o = 1'b1;
  logic pc, po, lc, lo;

  always #5 clk = ~clk;

  modulo_debouncer_botoes #(
    .STABLE_CYCLES(S),
    .REPEAT_OP_C  (RC),
    .REPEAT_OP    (RO),
    .CNT_W        (8)
  ) dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .btn_op_c_i  (btn_c),
    .btn_op_i    (btn_o),
    .op_c_pulse_o(pc),
    .op_pulse_o  (po),
    .op_c_level_o(lc),
    .op_level_o  (lo)
  );

  typedef struct packed {
    logic pc;
    logic po;
    logic lc;
    logic lo;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   dut_pc_cnt  = 0;
  int   dut_po_cnt  = 0;

  // Reference model: per key, length of the current pressed / released run as seen after
  // the two-stage synchroniser, and whether the pressed run began while the level was high.
  int rep_per[2] = '{RC, RO};
  int prun[2];
  int rrun[2];
  bit started_hi[2];
  bit lvl[2];
  bit s1m[2];
  bit s2m[2];

  task automatic model_edge(input bit clr_v, input bit [1:0] pressed_in, output exp_t e);
    bit pul[2];
    bit p;
    for (int ch = 0; ch < 2; ch++) begin
      pul[ch] = 1'b0;
      if (clr_v) begin
        prun[ch] = 0; rrun[ch] = 0; started_hi[ch] = 1'b0;
        lvl[ch] = 1'b0; s1m[ch] = 1'b0; s2m[ch] = 1'b0;
      end else begin
        p       = s2m[ch];
        s2m[ch] = s1m[ch];
        s1m[ch] = pressed_in[ch];
        if (p) begin
          prun[ch]++;
          rrun[ch] = 0;
          if (prun[ch] == 1) started_hi[ch] = lvl[ch];
        end else begin
          rrun[ch]++;
          prun[ch] = 0;
        end
        if (!lvl[ch]) begin
          if (p && prun[ch] == int'(S) + 1) begin
            lvl[ch] = 1'b1;
            pul[ch] = 1'b1;
          end
        end else if (!p) begin
          if (rrun[ch] == int'(S) + 1) lvl[ch] = 1'b0;
        end else if (rep_per[ch] != 0) begin
          if (started_hi[ch])
            pul[ch] = (prun[ch] > 1) && ((prun[ch] - 1) % rep_per[ch] == 0);
          else
            pul[ch] = (prun[ch] > int'(S) + 1) && ((prun[ch] - int'(S) - 1) % rep_per[ch] == 0);
        end
      end
    end
    e = '{pc: pul[0], po: pul[1], lc: lvl[0], lo: lvl[1]};
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after the next edge.
  task automatic step(input bit clr_v, input bit bc, input bit bo);
    exp_t e;
    @(negedge clk);
    clr   = clr_v;
    btn_c = bc;
    btn_o = bo;
    model_edge(clr_v, {~bo, ~bc}, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_count(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d pulses, expected %0d", name, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if ({pc, po, lc, lo} !== {mon_e.pc, mon_e.po, mon_e.lc, mon_e.lo}) begin
        miscompares++;
        $display("FAIL vec %0d @%0t: got pc=%b po=%b lc=%b lo=%b, expected pc=%b po=%b lc=%b lo=%b",
                 vectors, $time, pc, po, lc, lo, mon_e.pc, mon_e.po, mon_e.lc, mon_e.lo);
      end
      if (pc === 1'b1) dut_pc_cnt++;
      if (po === 1'b1) dut_po_cnt++;
    end
  end

  initial begin
    int snap_c, snap_o, hold_c, hold_o;
    bit bc, bo;

    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    idle(3);

    // 1: clean op_c hold of 20 cycles, repeat every 6
    settle(); snap_c = dut_pc_cnt;
    repeat (20) step(1'b0, 1'b0, 1'b1);
    idle(14);
    settle(); check_count("t1 op_c pulses", dut_pc_cnt - snap_c, 3);

    // 2: short op glitch
    snap_o = dut_po_cnt;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    idle(10);
    settle(); check_count("t2 op glitch pulses", dut_po_cnt - snap_o, 0);

    // 3: accepted op press, bouncy release
    snap_o = dut_po_cnt;
    repeat (10) step(1'b0, 1'b1, 1'b0);
    foreach (rep_per[i]) begin end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1);
    idle(12);
    settle(); check_count("t3 op bounce pulses", dut_po_cnt - snap_o, 1);

    // 4: both keys pressed together
    snap_c = dut_pc_cnt; snap_o = dut_po_cnt;
    repeat (10) step(1'b0, 1'b0, 1'b0);
    idle(14);
    settle();
    check_count("t4 op_c pulses", dut_pc_cnt - snap_c, 1);
    check_count("t4 op pulses", dut_po_cnt - snap_o, 1);

    // 5: clr on the 9th cycle of an op_c hold
    snap_c = dut_pc_cnt;
    repeat (8) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (16) step(1'b0, 1'b0, 1'b1);
    idle(14);
    settle(); check_count("t5 op_c pulses across clr", dut_pc_cnt - snap_c, 3);

    // 6: op hold and release without repeat
    snap_o = dut_po_cnt;
    repeat (8) step(1'b0, 1'b1, 1'b0);
    idle(14);
    settle(); check_count("t6 op pulses", dut_po_cnt - snap_o, 1);

    // Random key activity with occasional clr
    hold_c = 0; hold_o = 0; bc = 1'b1; bo = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (hold_c == 0) begin
        bc = 1'($urandom_range(0, 1));
        hold_c = int'($urandom_range(1, 14));
      end
      if (hold_o == 0) begin
        bo = 1'($urandom_range(0, 1));
        hold_o = int'($urandom_range(1, 14));
      end
      hold_c--; hold_o--;
      step(($urandom_range(0, 59) == 0), bc, bo);
    end
    idle(14);

    settle(); settle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
